mem_stage: RTL and testbench
============================

MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 Parameter: TIMEOUT, default 16, max WAIT cycles without dmem_ack before the access is abandoned.
REQ-002 Parameter: DW, default 32, data/address width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 MemtoReg_in, RegWrite_in, MemRead_in, MemWrite_in, Branch_in, zero_in  in  1 each  control from the EX/MEM register.
REQ-006 add_result_in, alu_result_in, read_data_2_in  in  32 each  branch target, ALU result/address, store data.
REQ-007 register_dest_in  in  5  destination register.
REQ-008 dmem_req, dmem_we  out  1 each  memory request; write enable, valid only with dmem_req.
REQ-009 dmem_addr, dmem_wdata  out  32 each  memory address and store data.
REQ-010 dmem_ack  in  1  memory completion; dmem_rdata  in  32  load data, valid with dmem_ack.
REQ-011 pc_src  out  1  branch taken; branch_target  out  32  taken-branch PC.
REQ-012 stall  out  1  hold all upstream stages this cycle.
REQ-013 mem_err  out  1  one-cycle pulse: misaligned access or timeout.
REQ-014 MemtoReg_out, RegWrite_out  out  1 each; read_data_out, alu_result_out  out  32 each; register_dest_out  out  5  MEM/WB register outputs.

Function
REQ-015 pc_src = Branch_in AND zero_in, combinational; branch_target = add_result_in, combinational.
REQ-016 FSM states IDLE, WAIT; mem op = MemRead_in OR MemWrite_in; misaligned = alu_result_in[1:0] != 0.
REQ-017 IDLE, no mem op: MEM/WB outputs capture inputs at next edge (1-cycle latency); read_data_out holds its previous value.
REQ-018 IDLE, aligned mem op: latch address, store data, we (=MemWrite_in) and control; stall=1 this cycle; go to WAIT; MEM/WB captures bubble (RegWrite_out=0, MemtoReg_out=0).
REQ-019 WAIT: dmem_req=1 with latched dmem_addr/dmem_wdata/dmem_we, held stable until ack or timeout; stall=1 while dmem_ack=0.
REQ-020 WAIT with dmem_ack=1: stall=0 that cycle; at the edge MEM/WB captures latched control, alu_result, and dmem_rdata as read_data_out (stores: read_data_out unchanged); go to IDLE.
REQ-021 Minimum memory-op latency is 2 cycles (IDLE + 1-cycle ack); dmem_ack seen in IDLE is ignored.
REQ-022 WAIT cycle counter counts from 0; when TIMEOUT cycles pass without ack, the WAIT cycle in which the counter reaches TIMEOUT-1 has stall=0; at that edge dmem_req drops, mem_err pulses next cycle, MEM/WB captures bubble, go to IDLE.
REQ-023 MemRead_in and MemWrite_in both set: treated as write.
REQ-024 Misaligned mem op in IDLE: no request, no stall; MEM/WB captures bubble; mem_err=1 next cycle.
REQ-025 Branch_in with mem op is not legal input; pc_src still follows REQ-015.

Reset
REQ-026 rst_n low asynchronously forces state IDLE, counter 0, latched regs 0, all MEM/WB outputs 0, mem_err 0; dmem_req, stall drop immediately, including mid-WAIT.
REQ-027 First edge after rst_n rises behaves as IDLE; an aborted access is not reissued.

Structure
REQ-028 Shared package mips_pkg holds state enum (IDLE, WAIT), DW and TIMEOUT defaults, register-index width 5.
REQ-029 MEM/WB output register is one sub-module, MEMWB_reg, with load and bubble inputs plus async active-low reset; FSM, counter, latches stay in mem_stage.

Verification
REQ-030 ALU op, RegWrite_in=1, alu_result_in=0x0000_00AA, dest=5 -> next cycle RegWrite_out=1, alu_result_out=0xAA, dest_out=5, stall never 1.
REQ-031 Load, addr 0x100, ack 3 cycles after req with rdata 0xDEAD_BEEF -> stall=1 for 3 cycles (IDLE+2 WAIT), 0 in ack cycle; next cycle read_data_out=0xDEAD_BEEF, MemtoReg_out=1.
REQ-032 Store addr 0x204, data 0x1234_5678, ack 1 cycle after req -> dmem_we=1, dmem_wdata=0x1234_5678 stable; RegWrite_out=0 afterward.
REQ-033 Load addr 0x102 -> no dmem_req, no stall, mem_err=1 one cycle, RegWrite_out=0.
REQ-034 Load, no ack, TIMEOUT=16 -> dmem_req high 16 cycles then low, mem_err one-cycle pulse, stall released; rst_n low mid-WAIT in rerun -> dmem_req and stall 0 same cycle.
REQ-035 Branch_in=1, zero_in=1, add_result_in=0x40 -> pc_src=1, branch_target=0x40 same cycle; zero_in=0 -> pc_src=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the MEM pipeline stage: FSM state encoding,
// default widths/timeout and a small alignment helper.
package mips_pkg;

    localparam int DW_DEFAULT      = 32;
    localparam int TIMEOUT_DEFAULT = 16;
    localparam int REG_IDX_W       = 5;

    // Memory access sequencer states.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } mem_state_e;

    // A word access is misaligned when either byte-offset bit is set.
    function automatic logic is_misaligned(input logic [1:0] lsb);
        return (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/MEMWB_reg.sv
// MEM/WB pipeline register. "bubble" clears the write-back controls so the
// WB stage does nothing; "load" captures a new result. read_data is only
// replaced when rdata_load is also set, so stores and ALU ops keep the last
// loaded value.
module MEMWB_reg
    import mips_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 bubble,
    input  logic                 rdata_load,
    input  logic                 memtoreg_in,
    input  logic                 regwrite_in,
    input  logic [DW-1:0]        alu_result_in,
    input  logic [DW-1:0]        read_data_in,
    input  logic [REG_IDX_W-1:0] reg_dest_in,
    output logic                 memtoreg_out,
    output logic                 regwrite_out,
    output logic [DW-1:0]        alu_result_out,
    output logic [DW-1:0]        read_data_out,
    output logic [REG_IDX_W-1:0] reg_dest_out
);

    logic                 memtoreg_q, memtoreg_d;
    logic                 regwrite_q, regwrite_d;
    logic [DW-1:0]        alu_result_q, alu_result_d;
    logic [DW-1:0]        read_data_q, read_data_d;
    logic [REG_IDX_W-1:0] reg_dest_q, reg_dest_d;

    // Next-value selection: bubble wins over load; otherwise hold.
    always_comb begin
        memtoreg_d   = memtoreg_q;
        regwrite_d   = regwrite_q;
        alu_result_d = alu_result_q;
        read_data_d  = read_data_q;
        reg_dest_d   = reg_dest_q;
        if (bubble) begin
            memtoreg_d = 1'b0;
            regwrite_d = 1'b0;
        end else if (load) begin
            memtoreg_d   = memtoreg_in;
            regwrite_d   = regwrite_in;
            alu_result_d = alu_result_in;
            reg_dest_d   = reg_dest_in;
            if (rdata_load) begin
                read_data_d = read_data_in;
            end
        end
    end

    // Register bank with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memtoreg_q   <= 1'b0;
            regwrite_q   <= 1'b0;
            alu_result_q <= '0;
            read_data_q  <= '0;
            reg_dest_q   <= '0;
        end else begin
            memtoreg_q   <= memtoreg_d;
            regwrite_q   <= regwrite_d;
            alu_result_q <= alu_result_d;
            read_data_q  <= read_data_d;
            reg_dest_q   <= reg_dest_d;
        end
    end

    assign memtoreg_out   = memtoreg_q;
    assign regwrite_out   = regwrite_q;
    assign alu_result_out = alu_result_q;
    assign read_data_out  = read_data_q;
    assign reg_dest_out   = reg_dest_q;

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage. Branch resolution is purely combinational. Loads and
// stores are latched in IDLE and issued to the data memory from WAIT, where
// the request is held stable until dmem_ack or until TIMEOUT cycles pass.
// Misaligned accesses and timeouts are squashed into a bubble and flagged
// with a one-cycle mem_err pulse.
//
// Memory handshake: dmem_req is high exactly while the sequencer is in WAIT,
// with dmem_addr/dmem_wdata/dmem_we stable for the whole request; the
// transfer completes in the first WAIT cycle that sees dmem_ack=1 (rdata is
// taken in that same cycle). dmem_ack outside WAIT is ignored.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT,
    parameter int DW      = DW_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 MemtoReg_in,
    input  logic                 RegWrite_in,
    input  logic                 MemRead_in,
    input  logic                 MemWrite_in,
    input  logic                 Branch_in,
    input  logic                 zero_in,
    input  logic [DW-1:0]        add_result_in,
    input  logic [DW-1:0]        alu_result_in,
    input  logic [DW-1:0]        read_data_2_in,
    input  logic [REG_IDX_W-1:0] register_dest_in,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [DW-1:0]        dmem_addr,
    output logic [DW-1:0]        dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [DW-1:0]        dmem_rdata,
    output logic                 pc_src,
    output logic [DW-1:0]        branch_target,
    output logic                 stall,
    output logic                 mem_err,
    output logic                 MemtoReg_out,
    output logic                 RegWrite_out,
    output logic [DW-1:0]        read_data_out,
    output logic [DW-1:0]        alu_result_out,
    output logic [REG_IDX_W-1:0] register_dest_out,
    output logic                 state_dbg
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    mem_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [DW-1:0]        addr_q, addr_d;
    logic [DW-1:0]        wdata_q, wdata_d;
    logic                 we_q, we_d;
    logic                 memtoreg_q, memtoreg_d;
    logic                 regwrite_q, regwrite_d;
    logic [REG_IDX_W-1:0] dest_q, dest_d;
    logic                 err_q, err_d;

    logic                 mem_op;
    logic                 misaligned;
    logic                 stall_raw;
    logic                 req;
    logic                 wb_load;
    logic                 wb_bubble;
    logic                 wb_rdata_load;
    logic                 wb_memtoreg;
    logic                 wb_regwrite;
    logic [DW-1:0]        wb_alu;
    logic [REG_IDX_W-1:0] wb_dest;

    assign mem_op     = MemRead_in | MemWrite_in;
    assign misaligned = is_misaligned(alu_result_in[1:0]);

    // Branch resolution needs no state.
    assign pc_src        = Branch_in & zero_in;
    assign branch_target = add_result_in;

    // Sequencer next state, access latches, stall and MEM/WB steering.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        we_d          = we_q;
        memtoreg_d    = memtoreg_q;
        regwrite_d    = regwrite_q;
        dest_d        = dest_q;
        err_d         = 1'b0;
        stall_raw     = 1'b0;
        req           = 1'b0;
        wb_load       = 1'b0;
        wb_bubble     = 1'b0;
        wb_rdata_load = 1'b0;
        wb_memtoreg   = MemtoReg_in;
        wb_regwrite   = RegWrite_in;
        wb_alu        = alu_result_in;
        wb_dest       = register_dest_in;

        case (state_q)
            IDLE: begin
                if (!mem_op) begin
                    wb_load = 1'b1;
                end else if (misaligned) begin
                    wb_bubble = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    // Read+write together is treated as a write.
                    addr_d     = alu_result_in;
                    wdata_d    = read_data_2_in;
                    we_d       = MemWrite_in;
                    memtoreg_d = MemtoReg_in;
                    regwrite_d = RegWrite_in;
                    dest_d     = register_dest_in;
                    cnt_d      = '0;
                    stall_raw  = 1'b1;
                    wb_bubble  = 1'b1;
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                req = 1'b1;
                if (dmem_ack) begin
                    wb_load       = 1'b1;
                    wb_memtoreg   = memtoreg_q;
                    wb_regwrite   = regwrite_q;
                    wb_alu        = addr_q;
                    wb_dest       = dest_q;
                    wb_rdata_load = ~we_q;
                    cnt_d         = '0;
                    state_d       = IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    // Last allowed cycle: release upstream and abandon.
                    wb_bubble = 1'b1;
                    err_d     = 1'b1;
                    cnt_d     = '0;
                    state_d   = IDLE;
                end else begin
                    stall_raw = 1'b1;
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer and access latches with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            we_q       <= 1'b0;
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            dest_q     <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            we_q       <= we_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            dest_q     <= dest_d;
            err_q      <= err_d;
        end
    end

    // stall must drop the moment reset asserts, even with a mem op presented.
    assign stall      = stall_raw & rst_n;
    assign dmem_req   = req;
    assign dmem_we    = we_q & req;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign mem_err    = err_q;
    assign state_dbg  = state_q;

    MEMWB_reg #(
        .DW(DW)
    ) u_memwb (
        .clk            (clk),
        .rst_n          (rst_n),
        .load           (wb_load),
        .bubble         (wb_bubble),
        .rdata_load     (wb_rdata_load),
        .memtoreg_in    (wb_memtoreg),
        .regwrite_in    (wb_regwrite),
        .alu_result_in  (wb_alu),
        .read_data_in   (dmem_rdata),
        .reg_dest_in    (wb_dest),
        .memtoreg_out   (MemtoReg_out),
        .regwrite_out   (RegWrite_out),
        .alu_result_out (alu_result_out),
        .read_data_out  (read_data_out),
        .reg_dest_out   (register_dest_out)
    );

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: directed scenarios with literal expectations plus a
// randomized instruction stream, checked every cycle against a
// transaction-level model of the stage.
module tb_mem_stage;
  localparam int TO = 16;
  localparam int DW = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic          MemtoReg_in = 0, RegWrite_in = 0, MemRead_in = 0, MemWrite_in = 0;
  logic          Branch_in = 0, zero_in = 0;
  logic [DW-1:0] add_result_in = '0, alu_result_in = '0, read_data_2_in = '0;
  logic [4:0]    register_dest_in = '0;
  logic          dmem_ack = 0;
  logic [DW-1:0] dmem_rdata = '0;
  logic          dmem_req, dmem_we, pc_src, stall, mem_err;
  logic          MemtoReg_out, RegWrite_out, state_dbg;
  logic [DW-1:0] dmem_addr, dmem_wdata, branch_target, read_data_out, alu_result_out;
  logic [4:0]    register_dest_out;

  mem_stage #(.TIMEOUT(TO), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemtoReg_in(MemtoReg_in), .RegWrite_in(RegWrite_in),
    .MemRead_in(MemRead_in), .MemWrite_in(MemWrite_in),
    .Branch_in(Branch_in), .zero_in(zero_in),
    .add_result_in(add_result_in), .alu_result_in(alu_result_in),
    .read_data_2_in(read_data_2_in), .register_dest_in(register_dest_in),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .pc_src(pc_src), .branch_target(branch_target), .stall(stall),
    .mem_err(mem_err), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .read_data_out(read_data_out), .alu_result_out(alu_result_out),
    .register_dest_out(register_dest_out), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_pass = 0;
  int stall_cnt = 0;
  int req_cnt = 0;

  // Expected values for the current cycle.
  logic          exp_stall = 0, exp_req = 0, exp_we = 0, exp_err = 0, pend_err = 0;
  logic [DW-1:0] exp_addr = '0, exp_wdata = '0;
  // Expected MEM/WB contents.
  logic          m_rw = 0, m_mtr = 0, m_data_valid = 1;
  logic [DW-1:0] m_alu = '0, m_rd = '0;
  logic [4:0]    m_dest = '0;
  // Queue of load data expected to reach read_data_out, in order.
  logic [DW-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("pc_src", pc_src, Branch_in & zero_in);
    chk("branch_target", branch_target, add_result_in);
    chk("stall", stall, exp_stall);
    chk("dmem_req", dmem_req, exp_req);
    if (exp_req) begin
      chk("dmem_addr", dmem_addr, exp_addr);
      chk("dmem_wdata", dmem_wdata, exp_wdata);
      chk("dmem_we", dmem_we, exp_we);
    end
    chk("mem_err", mem_err, exp_err);
    chk("RegWrite_out", RegWrite_out, m_rw);
    chk("MemtoReg_out", MemtoReg_out, m_mtr);
    chk("read_data_out", read_data_out, m_rd);
    if (m_data_valid) begin
      chk("alu_result_out", alu_result_out, m_alu);
      chk("register_dest_out", register_dest_out, m_dest);
    end
    if (stall) stall_cnt++;
    if (dmem_req) req_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic edge_step();
    @(posedge clk);
    #1;
    exp_err = pend_err;
    pend_err = 0;
  endtask

  task automatic wb_bubble();
    m_rw = 0;
    m_mtr = 0;
    m_data_valid = 0;
  endtask

  task automatic model_reset();
    exp_stall = 0; exp_req = 0; exp_err = 0; pend_err = 0;
    m_rw = 0; m_mtr = 0; m_alu = '0; m_rd = '0; m_dest = '0; m_data_valid = 1;
  endtask

  // Non-memory instruction: passes straight to MEM/WB after one edge.
  task automatic alu_op(input logic rw, input logic mtr, input logic [31:0] alu,
                        input logic [4:0] dest, input logic br, input logic z,
                        input logic [31:0] add);
    MemRead_in = 0; MemWrite_in = 0; RegWrite_in = rw; MemtoReg_in = mtr;
    Branch_in = br; zero_in = z; add_result_in = add; alu_result_in = alu;
    read_data_2_in = $urandom; register_dest_in = dest;
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    exp_stall = 0; exp_req = 0;
    edge_step();
    m_rw = rw; m_mtr = mtr; m_alu = alu; m_dest = dest; m_data_valid = 1;
  endtask

  // Load/store. ack_k = WAIT cycle index that sees dmem_ack (-1: never).
  task automatic mem_op(input logic rd, input logic wr, input logic rw, input logic mtr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] dest, input int ack_k, input logic [31:0] rdata);
    MemRead_in = rd; MemWrite_in = wr; RegWrite_in = rw; MemtoReg_in = mtr;
    Branch_in = 0; zero_in = 1'($urandom_range(0, 1)); add_result_in = $urandom;
    alu_result_in = addr; read_data_2_in = wdata; register_dest_in = dest;
    // Ack while idle must be ignored.
    dmem_ack = 1'($urandom_range(0, 1)); dmem_rdata = $urandom;
    exp_req = 0;
    if (addr[1:0] != 2'b00) begin
      exp_stall = 0;
      pend_err = 1;
      edge_step();
      wb_bubble();
      return;
    end
    exp_stall = 1;
    edge_step();
    wb_bubble();
    for (int k = 0; k < TO; k++) begin
      dmem_ack = (k == ack_k);
      dmem_rdata = (k == ack_k) ? rdata : $urandom;
      exp_req = 1; exp_addr = addr; exp_wdata = wdata; exp_we = wr;
      exp_stall = !((k == ack_k) || (k == TO - 1));
      if (k == ack_k) begin
        if (!wr) exp_q.push_back(rdata);
        edge_step();
        dmem_ack = 0;
        m_rw = rw; m_mtr = mtr; m_alu = addr; m_dest = dest; m_data_valid = 1;
        if (!wr) m_rd = exp_q.pop_front();
        return;
      end
      if (k == TO - 1) begin
        pend_err = 1;
        edge_step();
        dmem_ack = 0;
        wb_bubble();
        return;
      end
      edge_step();
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int kind;
    int r;
    int ak;
    logic [31:0] a;

    #2 rst_n = 0;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset RegWrite_out", RegWrite_out, 0);
    chk("reset read_data_out", read_data_out, 0);
    chk("reset dmem_req", dmem_req, 0);
    chk("reset mem_err", mem_err, 0);
    #2 rst_n = 1;
    alu_op(0, 0, 32'h0, 5'd0, 0, 0, 32'h0);

    // ALU op passes through with one-cycle latency.
    stall_cnt = 0;
    alu_op(1, 0, 32'h0000_00AA, 5'd5, 0, 0, 32'h0);
    chk("alu RegWrite_out", RegWrite_out, 1);
    chk("alu alu_result_out", alu_result_out, 32'h0000_00AA);
    chk("alu dest_out", register_dest_out, 5);

    // Load, ack on the third request cycle.
    stall_cnt = 0; req_cnt = 0;
    mem_op(1, 0, 1, 1, 32'h0000_0100, 32'h0, 5'd9, 2, 32'hDEAD_BEEF);
    chk("load stall cycles", stall_cnt, 3);
    chk("load req cycles", req_cnt, 3);
    chk("load read_data_out", read_data_out, 32'hDEAD_BEEF);
    chk("load MemtoReg_out", MemtoReg_out, 1);

    // Store, ack on first request cycle.
    mem_op(0, 1, 0, 0, 32'h0000_0204, 32'h1234_5678, 5'd3, 0, 32'h5555_5555);
    chk("store RegWrite_out", RegWrite_out, 0);
    chk("store read_data_out kept", read_data_out, 32'hDEAD_BEEF);

    // Misaligned load.
    stall_cnt = 0; req_cnt = 0;
    mem_op(1, 0, 1, 1, 32'h0000_0102, 32'h0, 5'd4, 0, 32'h0);
    chk("misaligned mem_err", mem_err, 1);
    chk("misaligned RegWrite_out", RegWrite_out, 0);
    chk("misaligned stall cycles", stall_cnt, 0);
    chk("misaligned req cycles", req_cnt, 0);

    // Load with no ack: timeout.
    stall_cnt = 0; req_cnt = 0;
    mem_op(1, 0, 1, 1, 32'h0000_0300, 32'h0, 5'd6, -1, 32'h0);
    chk("timeout req cycles", req_cnt, TO);
    chk("timeout stall cycles", stall_cnt, TO);
    chk("timeout mem_err", mem_err, 1);
    chk("timeout RegWrite_out", RegWrite_out, 0);
    alu_op(0, 0, 32'h8, 5'd1, 0, 0, 32'h0);
    chk("timeout mem_err cleared", mem_err, 0);

    // Branch resolution.
    alu_op(0, 0, 32'h10, 5'd2, 1, 1, 32'h0000_0040);
    #1;
    chk("branch pc_src", pc_src, 1);
    chk("branch target", branch_target, 32'h0000_0040);
    zero_in = 0;
    #1;
    chk("branch not taken", pc_src, 0);

    // Reset in the middle of a WAIT.
    MemRead_in = 1; MemWrite_in = 0; RegWrite_in = 1; MemtoReg_in = 1; Branch_in = 0;
    alu_result_in = 32'h0000_0400; register_dest_in = 5'd8; dmem_ack = 0;
    exp_stall = 1; exp_req = 0;
    edge_step();
    wb_bubble();
    for (int k = 0; k < 3; k++) begin
      exp_req = 1; exp_addr = 32'h0000_0400; exp_wdata = read_data_2_in; exp_we = 0;
      exp_stall = 1;
      edge_step();
    end
    exp_req = 1; exp_stall = 1;
    #1 rst_n = 0;
    model_reset();
    #1;
    chk("mid-wait reset dmem_req", dmem_req, 0);
    chk("mid-wait reset stall", stall, 0);
    chk("mid-wait reset RegWrite_out", RegWrite_out, 0);
    edge_step();
    MemRead_in = 0; RegWrite_in = 1; MemtoReg_in = 0;
    alu_result_in = 32'h0000_0077; register_dest_in = 5'd11;
    exp_stall = 0; exp_req = 0;
    #2 rst_n = 1;
    edge_step();
    m_rw = 1; m_mtr = 0; m_alu = 32'h0000_0077; m_dest = 5'd11; m_data_valid = 1;
    chk("after reset no reissue", dmem_req, 0);

    // Randomized instruction stream.
    for (int i = 0; i < 250; i++) begin
      kind = $urandom_range(0, 9);
      r = $urandom_range(0, 9);
      ak = (r == 0) ? -1 : (r == 1) ? TO - 1 : $urandom_range(0, 4);
      a = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      case (kind)
        0, 1, 2, 3:
          alu_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
        4, 5: mem_op(1, 0, 1, 1, a, $urandom, 5'($urandom_range(0, 31)), ak, $urandom);
        6, 7: mem_op(0, 1, 0, 0, a, $urandom, 5'($urandom_range(0, 31)), ak, $urandom);
        8: mem_op(1, 1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                  5'($urandom_range(0, 31)), ak, $urandom);
        default: mem_op(1'($urandom_range(0, 1)), 1, 1, 1, a | 32'($urandom_range(1, 3)),
                        $urandom, 5'($urandom_range(0, 31)), 0, $urandom);
      endcase
    end
    alu_op(0, 0, 32'h0, 5'd0, 0, 0, 32'h0);
    alu_op(0, 0, 32'h0, 5'd0, 0, 0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
